adc_wave_meas: RTL and testbench

Waveform measurement block. It is the capture-side counterpart to the DDS generators (saw/sine/square). It consumes two 14-bit offset-binary sample streams (channel A and channel B, mid-scale 8192), e.g. DAC loopback through the board ADC. For channel A it measures period (in samples) and peak-to-peak amplitude. It also measures the delay from a channel-A rising mid-scale crossing to the next channel-B rising mid-scale crossing. Results feed the control/UI register file for closed-loop checking of freq/amp/phase settings.

---
 rtl/adc_wave_meas_pkg.sv | 8 +
 rtl/adc_wave_meas_schmitt_edge_det.sv | 23 ++
 rtl/adc_wave_meas.sv | 93 +++++++++
 tb/tb_adc_wave_meas.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/adc_wave_meas_pkg.sv
// awg_meas_pkg: shared defaults and FSM state type for the waveform measurement block
package awg_meas_pkg;
  localparam int DEF_DATA_W = 14;
  localparam int DEF_CNT_W  = 24;
  localparam int DEF_MID    = 8192;
  localparam int DEF_HYST   = 64;
  typedef enum logic [1:0] {IDLE, ARM, MEASURE} meas_state_t;
endpackage

// File: rtl/adc_wave_meas_schmitt_edge_det.sv
// schmitt_edge_det: hysteretic mid-scale comparator flagging rising crossings combinationally
module schmitt_edge_det
  import awg_meas_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int MID    = DEF_MID,
  parameter int HYST   = DEF_HYST
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sample_valid,
  input  logic [DATA_W-1:0] din,
  output logic              edge_out
);
  localparam logic [DATA_W-1:0] HI = DATA_W'(MID + HYST);
  localparam logic [DATA_W-1:0] LO = DATA_W'(MID - HYST);
  logic hi;
  assign edge_out = sample_valid && !hi && din >= HI;
  // track the comparator level; only a LOW->HIGH flip counts as an edge
  always_ff @(posedge clk or posedge rst)
    if (rst) hi <= 1'b0;
    else if (sample_valid) hi <= hi ? (din > LO) : (din >= HI);
endmodule

// File: rtl/adc_wave_meas.sv
// adc_wave_meas: channel-A period/peak-to-peak and A->B rising-crossing delay measurement
module adc_wave_meas
  import awg_meas_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int CNT_W  = DEF_CNT_W,
  parameter int MID    = DEF_MID,
  parameter int HYST   = DEF_HYST
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              sample_valid,
  input  logic [DATA_W-1:0] adc_in_A,
  input  logic [DATA_W-1:0] adc_in_B,
  output logic [CNT_W-1:0]  period,
  output logic [DATA_W-1:0] amp_pp,
  output logic [CNT_W-1:0]  phase_cnt,
  output logic              phase_ok,
  output logic              meas_valid,
  output logic              timeout
);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  meas_state_t state, state_nx;
  logic edge_a, edge_b, start, close, step, sat, phase_seen;
  logic [CNT_W-1:0] cnt, phase_reg;
  logic [DATA_W-1:0] mn, mx, mn_nx, mx_nx;

  schmitt_edge_det #(.DATA_W(DATA_W), .MID(MID), .HYST(HYST)) u_det_a (
    .clk(clk), .rst(rst), .sample_valid(sample_valid), .din(adc_in_A), .edge_out(edge_a)
  );
  schmitt_edge_det #(.DATA_W(DATA_W), .MID(MID), .HYST(HYST)) u_det_b (
    .clk(clk), .rst(rst), .sample_valid(sample_valid), .din(adc_in_B), .edge_out(edge_b)
  );

  // decode the sample event and next state; saturation fires when cnt would reach all-ones
  always_comb begin
    start    = en && sample_valid && edge_a && state != IDLE;
    close    = start && state == MEASURE;
    step     = en && sample_valid && !edge_a && state == MEASURE;
    sat      = step && cnt == CNT_MAX - 1'b1;
    mn_nx    = adc_in_A < mn ? adc_in_A : mn;
    mx_nx    = adc_in_A > mx ? adc_in_A : mx;
    state_nx = !en ? IDLE : !sample_valid ? state : state == IDLE ? ARM :
               start ? MEASURE : sat ? ARM : state;
  end

  // state register
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nx;

  // running period statistics and the published result set
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt        <= '0;
      mn         <= '1;
      mx         <= '0;
      phase_reg  <= '0;
      phase_seen <= 1'b0;
      period     <= '0;
      amp_pp     <= '0;
      phase_cnt  <= '0;
      phase_ok   <= 1'b0;
      meas_valid <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      meas_valid <= close;
      if (close) begin
        period    <= cnt;
        amp_pp    <= mx_nx - mn_nx;
        phase_cnt <= phase_reg;
        phase_ok  <= phase_seen;
        timeout   <= 1'b0;
      end
      if (sat) timeout <= 1'b1;
      if (start) begin
        cnt        <= CNT_W'(1);
        mn         <= adc_in_A;
        mx         <= adc_in_A;
        phase_reg  <= '0;
        phase_seen <= edge_b;
      end else if (step) begin
        cnt <= cnt + 1'b1;
        mn  <= mn_nx;
        mx  <= mx_nx;
        if (edge_b && !phase_seen) begin
          phase_reg  <= cnt;
          phase_seen <= 1'b1;
        end
      end
    end
endmodule

// File: tb/tb_adc_wave_meas.sv
// tb_adc_wave_meas: table-driven and randomized checks against a sample-window reference model
module tb_adc_wave_meas;
  import awg_meas_pkg::*;
  localparam int HI = DEF_MID + DEF_HYST;
  localparam int LO = DEF_MID - DEF_HYST;
  localparam int CMAX = (1 << DEF_CNT_W) - 1;

  logic clk = 1'b0, rst = 1'b1, en = 1'b0, sample_valid = 1'b0;
  logic [13:0] adc_a = '0, adc_b = '0;
  logic [23:0] period, phase_cnt;
  logic [13:0] amp_pp;
  logic phase_ok, meas_valid, timeout;
  logic [7:0] s_period, s_phase_cnt;
  logic [13:0] s_amp_pp;
  logic s_phase_ok, s_meas_valid, s_timeout;

  adc_wave_meas dut (
    .clk(clk), .rst(rst), .en(en), .sample_valid(sample_valid),
    .adc_in_A(adc_a), .adc_in_B(adc_b), .period(period), .amp_pp(amp_pp),
    .phase_cnt(phase_cnt), .phase_ok(phase_ok), .meas_valid(meas_valid), .timeout(timeout)
  );
  adc_wave_meas #(.CNT_W(8)) dut_s (
    .clk(clk), .rst(rst), .en(en), .sample_valid(sample_valid),
    .adc_in_A(adc_a), .adc_in_B(adc_b), .period(s_period), .amp_pp(s_amp_pp),
    .phase_cnt(s_phase_cnt), .phase_ok(s_phase_ok), .meas_valid(s_meas_valid), .timeout(s_timeout)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_err = 0, n_pub = 0, s_pub = 0;
  int m_ha, m_hb, m_st, m_first;
  int wa[$];
  int e_period, e_amp, e_phase, e_ok, e_mv, e_to;

  typedef struct {int per; int boff; bit bz; int ep; int eamp; int eph; bit eok;} vec_t;
  vec_t tv[4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [13:0] saw(input int i, input int p);
    return 14'((i % p) * 16384 / p);
  endfunction

  function automatic logic [13:0] noise();
    return 14'(DEF_MID - 40 + int'($urandom_range(0, 80)));
  endfunction

  task automatic model_reset();
    m_ha = 0; m_hb = 0; m_st = 0; m_first = -1; wa.delete();
    e_period = 0; e_amp = 0; e_phase = 0; e_ok = 0; e_mv = 0; e_to = 0;
  endtask

  // Model: keep every A sample of the open period in a window; results are derived from it at close.
  task automatic model_step();
    bit ea, eb;
    int mx, mn;
    ea = sample_valid && m_ha == 0 && int'(adc_a) >= HI;
    eb = sample_valid && m_hb == 0 && int'(adc_b) >= HI;
    if (sample_valid) begin
      m_ha = m_ha != 0 ? int'(int'(adc_a) > LO) : int'(int'(adc_a) >= HI);
      m_hb = m_hb != 0 ? int'(int'(adc_b) > LO) : int'(int'(adc_b) >= HI);
    end
    e_mv = 0;
    if (!en) m_st = 0;
    else if (sample_valid) begin
      if (m_st == 0) m_st = 1;
      else if (ea) begin
        if (m_st == 2) begin
          mx = int'(adc_a); mn = int'(adc_a);
          foreach (wa[k]) begin
            if (wa[k] > mx) mx = wa[k];
            if (wa[k] < mn) mn = wa[k];
          end
          e_period = wa.size(); e_amp = mx - mn;
          e_ok = int'(m_first >= 0); e_phase = m_first >= 0 ? m_first : 0;
          e_mv = 1; e_to = 0;
        end
        wa.delete(); wa.push_back(int'(adc_a));
        m_first = eb ? 0 : -1; m_st = 2;
      end else if (m_st == 2) begin
        if (eb && m_first < 0) m_first = wa.size();
        wa.push_back(int'(adc_a));
        if (wa.size() == CMAX) begin e_to = 1; m_st = 1; end
      end
    end
  endtask

  task automatic check_all();
    chk("period", 32'(period), e_period);
    chk("amp_pp", 32'(amp_pp), e_amp);
    chk("phase_cnt", 32'(phase_cnt), e_phase);
    chk("phase_ok", 32'(phase_ok), e_ok);
    chk("meas_valid", 32'(meas_valid), e_mv);
    chk("timeout", 32'(timeout), e_to);
    if (meas_valid) n_pub++;
    if (s_meas_valid) s_pub++;
  endtask

  task automatic drive(input logic e, input logic v, input logic [13:0] a, input logic [13:0] b);
    en = e; sample_valid = v; adc_a = a; adc_b = b;
    model_step();
    @(posedge clk); #1;
    check_all();
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b0; sample_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    int first, sp, sa;
    logic [13:0] ra;
    tv[0] = '{1024, 256, 1'b0, 1024, 16368, 768, 1'b1};
    tv[1] = '{1024, 0,   1'b0, 1024, 16368, 0,   1'b1};
    tv[2] = '{500,  0,   1'b1, 500,  16351, 0,   1'b0};
    tv[3] = '{100,  25,  1'b0, 100,  16220, 75,  1'b1};

    repeat (2) @(posedge clk);
    #1;
    chk("rst_period", 32'(period), 0);
    chk("rst_amp", 32'(amp_pp), 0);
    chk("rst_phase", 32'(phase_cnt), 0);
    chk("rst_ok", 32'(phase_ok), 0);
    chk("rst_mv", 32'(meas_valid), 0);
    chk("rst_to", 32'(timeout), 0);
    rst = 1'b0;
    model_reset();

    for (int t = 0; t < 4; t++) begin
      do_reset();
      n_pub = 0;
      for (int i = 0; i < 3 * tv[t].per; i++)
        drive(1'b1, 1'b1, saw(i, tv[t].per), tv[t].bz ? 14'd0 : saw(i + tv[t].boff, tv[t].per));
      chk("tbl_period", 32'(period), tv[t].ep);
      chk("tbl_amp", 32'(amp_pp), tv[t].eamp);
      chk("tbl_phase", 32'(phase_cnt), tv[t].eph);
      chk("tbl_ok", 32'(phase_ok), 32'(tv[t].eok));
      chk("tbl_npub", n_pub, 2);
    end

    // en dropped mid-period: A edges at 101+200k; re-armed at 410, so first new close is sample 701
    do_reset();
    for (int i = 0; i < 400; i++) drive(1'b1, 1'b1, saw(i, 200), 14'd0);
    sp = int'(period); sa = int'(amp_pp);
    for (int i = 400; i < 410; i++) begin
      drive(1'b0, 1'b1, saw(i, 200), 14'd0);
      chk("gap_period", 32'(period), sp);
      chk("gap_amp", 32'(amp_pp), sa);
      chk("gap_mv", 32'(meas_valid), 0);
    end
    first = -1;
    for (int i = 410; i < 900 && first < 0; i++) begin
      drive(1'b1, 1'b1, saw(i, 200), 14'd0);
      if (meas_valid) first = i;
    end
    chk("reen_first_result", first, 701);

    // strobe every 4th clock, 100-sample period
    do_reset();
    for (int j = 0; j < 1200; j++) begin
      drive(1'b1, j % 4 == 0, saw(j / 4, 100), 14'd0);
      if (meas_valid) chk("sv4_mv_after_strobe", j % 4, 0);
    end
    chk("sv4_period", 32'(period), 100);

    // async reset mid-measurement
    do_reset();
    for (int i = 0; i < 200; i++) drive(1'b1, 1'b1, saw(i, 100), saw(i, 100));
    chk("pre_rst_period", 32'(period), 100);
    rst = 1'b1;
    #1;
    chk("arst_period", 32'(period), 0);
    chk("arst_amp", 32'(amp_pp), 0);
    chk("arst_phase", 32'(phase_cnt), 0);
    chk("arst_ok", 32'(phase_ok), 0);
    chk("arst_mv", 32'(meas_valid), 0);
    chk("arst_to", 32'(timeout), 0);
    @(posedge clk); #1;
    chk("arst_mv_edge", 32'(meas_valid), 0);
    rst = 1'b0;
    model_reset();
    for (int i = 200; i < 260; i++) drive(1'b1, 1'b1, saw(i, 100), saw(i, 100));

    // noise inside hysteresis on the 8-bit-counter instance: no timeout while in ARM
    do_reset();
    s_pub = 0;
    for (int i = 0; i < 300; i++) drive(1'b1, 1'b1, noise(), noise());
    chk("arm_noise_to", 32'(s_timeout), 0);
    chk("arm_noise_period", 32'(s_period), 0);
    chk("arm_noise_amp", 32'(s_amp_pp), 0);
    drive(1'b1, 1'b1, 14'd9000, noise());
    for (int i = 0; i < 253; i++) drive(1'b1, 1'b1, noise(), noise());
    chk("sat_before", 32'(s_timeout), 0);
    drive(1'b1, 1'b1, noise(), noise());
    chk("sat_at", 32'(s_timeout), 1);
    chk("sat_period_held", 32'(s_period), 0);
    chk("noise_no_mv", s_pub, 0);

    // randomized traffic against the model
    do_reset();
    ra = '0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 2) == 0) ra = 14'($urandom_range(0, 16383));
      drive($urandom_range(0, 299) != 0, $urandom_range(0, 3) != 0, ra,
            $urandom_range(0, 1) != 0 ? ra : 14'($urandom_range(0, 16383)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
